aeolus_multicycle_sequencer: RTL and testbench
==============================================

Name: aeolus_multicycle_sequencer

Overview:
Multi-cycle control FSM for the Aeolus CPU datapath. It sequences each 4-bit instruction through FETCH/DECODE/EXEC/WB, replacing the single-cycle decoder timing. It drives the PC enable, instruction latch, one-hot datapath strobes and ACC enable. It also provides run/pause/single-step control for board bring-up.

Parameters:
OPCODE_WIDTH, 4, instruction width; fixes ctrl width at 2**OPCODE_WIDTH
COUNT_WIDTH, 8, width of retired-instruction counter

Ports:
clk  in  1  system clock (divided board clock)
reset  in  1  asynchronous, active-low reset
run  in  1  level; 1 = execute, 0 = stop at next instruction boundary
step_mode  in  1  level; 1 = pause after every retired instruction
step  in  1  level (button); a rising edge releases one instruction from PAUSE
opcode  in  OPCODE_WIDTH  instruction word from program ROM at current PC
sf  in  1  shift flag from shift register
ir  out  OPCODE_WIDTH  latched instruction register
ir_load  out  1  IR capture strobe (FETCH)
ctrl  out  2**OPCODE_WIDTH  one-hot datapath strobe, bit index = ir
add_force  out  1  forces ALU ADD for taken SNZA/SNZS
acc_en  out  1  ACC write enable
pc_en  out  1  PC increment enable; marks instruction retirement
busy  out  1  1 in FETCH/DECODE/EXEC/WB
retired  out  COUNT_WIDTH  retired-instruction count

Behaviour:
- Opcode map: 0 LDA, 1 LDB, 2 LDO, 3 LDSA, 4 LDSB, 5 LSH, 6 RSH, 7 CLR, 8 SNZA, 9 SNZS, A ADD, B SUB, C AND, D OR, E XOR, F INV.
- Reset (async, reset=0): state IDLE; ir=0, retired=0, step_q=0, sf_q=0; all strobes and busy are 0. A reset asserted mid-instruction aborts it immediately with no partial strobes. The PC is not advanced.
- States: IDLE, FETCH, DECODE, EXEC, WB, PAUSE. All outputs are registered-state decodes with no input-to-output combinational paths, except next-state logic.
- IDLE: run=1 -> FETCH.
- FETCH: ir_load=1; ir <= opcode at the clock edge -> DECODE.
- DECODE: sf_q <= sf -> EXEC.
- EXEC, class S (0-7): ctrl[ir]=1 and pc_en=1. CLR also asserts acc_en. The instruction retires here (3 cycles total).
- EXEC, class C not taken (8/9 with sf_q=0): ctrl=0, pc_en=1. The instruction retires (3 cycles).
- EXEC, class A (A-F) or taken C (sf_q=1): ctrl[ir]=1 (plus add_force for C) -> WB.
- WB: ctrl, add_force held identical to EXEC; acc_en=1, pc_en=1. The instruction retires (4 cycles total).
- Retire cycle: retired <= retired+1, wrapping from 2**COUNT_WIDTH-1 to 0.
- Next state after retire, by priority:
  - run=0 -> IDLE;
  - step_mode=1 -> PAUSE;
  - otherwise -> FETCH.
- PAUSE:
  - run=0 -> IDLE (highest priority);
  - step rising edge (step & ~step_q) -> FETCH.
- step_q samples step every cycle in all states. Edges outside PAUSE are discarded. A held button releases exactly one instruction.
- Deasserting run mid-instruction does not abort; the instruction completes and retires first.
- step_mode changes are honoured only at the retire cycle.
- Exactly one ctrl bit, or none, is high in any cycle. pc_en is high for exactly one cycle per instruction.

Test Plan:
1. Reset: hold reset=0 with run=1 and opcode=A -> ir=0, ctrl=0, pc_en=0, acc_en=0, busy=0, retired=0. Release reset -> ir_load=1 on the first FETCH cycle.
2. Free run, opcode stream 0 then A (run=1, step_mode=0):
   - LDA: ctrl=0x0001 with pc_en=1 in cycle 3.
   - ADD: ctrl=0x0400 for cycles 6-7; acc_en=pc_en=1 only in cycle 7.
   - Result: retired=2.
3. SNZA with sf=1 at DECODE -> ctrl=0x0100 and add_force=1 for 2 cycles, acc_en in WB. Repeat with sf=0 -> ctrl=0, add_force=0, acc_en=0, pc_en in EXEC (3 cycles). Also LDO in EXEC -> ctrl=0x0004.
4. step_mode=1, step held high for 10 cycles -> one instruction retires, FSM rests in PAUSE with busy=0. Release and re-press step -> exactly one more retire (retired=2).
5. run dropped in EXEC of SUB -> WB still asserts acc_en and pc_en, then IDLE. No further ir_load.
6. Run 256 CLR instructions -> retired wraps to 0. Assert reset during WB of an XOR -> acc_en and pc_en fall to 0 immediately, and state is IDLE.

Source files
------------

// File: rtl/aeolus_multicycle_sequencer.sv
// Multi-cycle control sequencer for the Aeolus datapath: FETCH/DECODE/EXEC[/WB] per instruction,
// with run/pause/single-step control. Every output is a flop, cleared asynchronously on reset.
module aeolus_multicycle_sequencer #(
  parameter int OPCODE_WIDTH = 4,
  parameter int COUNT_WIDTH  = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          run,
  input  logic                          step_mode,
  input  logic                          step,
  input  logic [OPCODE_WIDTH-1:0]       opcode,
  input  logic                          sf,
  output logic [OPCODE_WIDTH-1:0]       ir,
  output logic                          ir_load,
  output logic [(2**OPCODE_WIDTH)-1:0]  ctrl,
  output logic                          add_force,
  output logic                          acc_en,
  output logic                          pc_en,
  output logic                          busy,
  output logic [COUNT_WIDTH-1:0]        retired
);

  localparam int CtrlWidth = 2**OPCODE_WIDTH;
  localparam logic [OPCODE_WIDTH-1:0] OpClr  = OPCODE_WIDTH'(7);
  localparam logic [OPCODE_WIDTH-1:0] OpSnza = OPCODE_WIDTH'(8);
  localparam logic [OPCODE_WIDTH-1:0] OpSnzs = OPCODE_WIDTH'(9);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB, PAUSE} state_e;

  state_e                  state_q, state_d;
  logic [OPCODE_WIDTH-1:0] ir_q, ir_d;
  logic                    sf_q, sf_d;
  logic                    step_q;
  logic [COUNT_WIDTH-1:0]  retired_q;
  logic [CtrlWidth-1:0]    ctrl_q, ctrl_d;
  logic                    ir_load_q, add_force_q, add_force_d;
  logic                    acc_en_q, acc_en_d, pc_en_q, pc_en_d, busy_q;
  logic                    cur_cond, cur_short, retire;
  logic                    nxt_cond, nxt_skip, nxt_short;

  // "short" instructions retire in EXEC: class S, or a conditional whose flag was clear.
  always_comb begin
    cur_cond  = (ir_q == OpSnza) || (ir_q == OpSnzs);
    cur_short = (ir_q < OpSnza) || (cur_cond && !sf_q);
    retire    = ((state_q == EXEC) && cur_short) || (state_q == WB);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (run) state_d = FETCH;
      FETCH:    state_d = DECODE;
      DECODE:   state_d = EXEC;
      EXEC, WB: begin
        if (!retire)        state_d = WB;
        else if (!run)      state_d = IDLE;
        else if (step_mode) state_d = PAUSE;
        else                state_d = FETCH;
      end
      PAUSE: begin
        if (!run)                state_d = IDLE;
        else if (step && !step_q) state_d = FETCH;
      end
      default:  state_d = IDLE;
    endcase
  end

  assign ir_d = (state_q == FETCH)  ? opcode : ir_q;
  assign sf_d = (state_q == DECODE) ? sf     : sf_q;

  // Strobes are decoded from the upcoming state so they appear registered in that state.
  always_comb begin
    nxt_cond    = (ir_d == OpSnza) || (ir_d == OpSnzs);
    nxt_skip    = nxt_cond && !sf_d;
    nxt_short   = (ir_d < OpSnza) || nxt_skip;
    ctrl_d      = '0;
    add_force_d = 1'b0;
    acc_en_d    = 1'b0;
    pc_en_d     = 1'b0;
    if (state_d == EXEC) begin
      if (!nxt_skip)       ctrl_d      = CtrlWidth'(1) << ir_d;
      if (!nxt_short)      add_force_d = nxt_cond;
      if (nxt_short)       pc_en_d     = 1'b1;
      if (ir_d == OpClr)   acc_en_d    = 1'b1;
    end else if (state_d == WB) begin
      ctrl_d      = CtrlWidth'(1) << ir_d;
      add_force_d = nxt_cond;
      acc_en_d    = 1'b1;
      pc_en_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      ir_q        <= '0;
      sf_q        <= 1'b0;
      step_q      <= 1'b0;
      retired_q   <= '0;
      ir_load_q   <= 1'b0;
      ctrl_q      <= '0;
      add_force_q <= 1'b0;
      acc_en_q    <= 1'b0;
      pc_en_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      sf_q        <= sf_d;
      step_q      <= step;
      if (retire) retired_q <= retired_q + COUNT_WIDTH'(1);
      ir_load_q   <= (state_d == FETCH);
      ctrl_q      <= ctrl_d;
      add_force_q <= add_force_d;
      acc_en_q    <= acc_en_d;
      pc_en_q     <= pc_en_d;
      busy_q      <= (state_d != IDLE) && (state_d != PAUSE);
    end
  end

  assign ir        = ir_q;
  assign ir_load   = ir_load_q;
  assign ctrl      = ctrl_q;
  assign add_force = add_force_q;
  assign acc_en    = acc_en_q;
  assign pc_en     = pc_en_q;
  assign busy      = busy_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_aeolus_multicycle_sequencer.sv
// Directed bench for aeolus_multicycle_sequencer: free run, conditional skips, single-step,
// run drop, counter wrap and mid-instruction reset, each against hand-computed strobe values.
module tb_aeolus_multicycle_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        run, stepMode, step, sf;
  logic [3:0]  opcode, ir;
  logic        irLoad, addForce, accEn, pcEn, busy;
  logic [15:0] ctrl;
  logic [7:0]  retired;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  aeolus_multicycle_sequencer #(.OPCODE_WIDTH(4), .COUNT_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .run(run), .step_mode(stepMode), .step(step),
    .opcode(opcode), .sf(sf), .ir(ir), .ir_load(irLoad), .ctrl(ctrl),
    .add_force(addForce), .acc_en(accEn), .pc_en(pcEn), .busy(busy), .retired(retired)
  );

  task automatic applyStimulus(input logic runV, input logic stepModeV, input logic stepV,
                               input logic [3:0] opV, input logic sfV);
    run = runV; stepMode = stepModeV; step = stepV; opcode = opV; sf = sfV;
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Packs {ctrl, add_force, acc_en, pc_en, busy, ir_load} into one comparison.
  task automatic checkStrobes(input string tag, input logic [15:0] ctrlE, input logic afE,
                              input logic accE, input logic pcE, input logic busyE, input logic irlE);
    checkOutput(tag, {11'b0, ctrl, addForce, accEn, pcEn, busy, irLoad},
                     {11'b0, ctrlE, afE, accE, pcE, busyE, irlE});
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      total++;
      assert ($onehot0(ctrl)) else begin
        bad++;
        $error("[TB] FAIL ctrl_onehot observed=0x%0h expected=at most one bit", ctrl);
      end
    end
  end

  initial begin
    reset = 1'b0;
    applyStimulus(1, 0, 0, 4'hA, 0);
    #12;
    checkStrobes("reset_strobes", 16'h0000, 0, 0, 0, 0, 0);
    checkOutput("reset_ir", ir, 4'h0);
    checkOutput("reset_retired", retired, 8'd0);

    // Free run: LDA then ADD
    applyStimulus(1, 0, 0, 4'h0, 0);
    reset = 1'b1;
    tick(1); checkStrobes("c1_fetch", 16'h0000, 0, 0, 0, 1, 1);
    tick(1); checkStrobes("c2_decode", 16'h0000, 0, 0, 0, 1, 0);
    tick(1); checkStrobes("c3_lda_exec", 16'h0001, 0, 0, 1, 1, 0);
    applyStimulus(1, 0, 0, 4'hA, 0);
    tick(1); checkOutput("lda_retired", retired, 8'd1);
             checkStrobes("c4_fetch", 16'h0000, 0, 0, 0, 1, 1);
    tick(1); checkOutput("add_ir", ir, 4'hA);
    tick(1); checkStrobes("c6_add_exec", 16'h0400, 0, 0, 0, 1, 0);
    tick(1); checkStrobes("c7_add_wb", 16'h0400, 0, 1, 1, 1, 0);
    tick(1); checkOutput("free_run_retired", retired, 8'd2);

    // SNZA taken, then not taken, then LDO (step_mode armed for the LDO retire)
    applyStimulus(1, 0, 0, 4'h8, 1);
    tick(1); checkOutput("snza_ir", ir, 4'h8);
    tick(1); checkStrobes("snza_taken_exec", 16'h0100, 1, 0, 0, 1, 0);
    tick(1); checkStrobes("snza_taken_wb", 16'h0100, 1, 1, 1, 1, 0);
    tick(1); checkOutput("snza_taken_retired", retired, 8'd3);
    applyStimulus(1, 0, 0, 4'h8, 0);
    tick(2); checkStrobes("snza_skip_exec", 16'h0000, 0, 0, 1, 1, 0);
    tick(1); checkStrobes("snza_skip_fetch", 16'h0000, 0, 0, 0, 1, 1);
             checkOutput("snza_skip_retired", retired, 8'd4);
    applyStimulus(1, 1, 0, 4'h2, 0);
    tick(2); checkStrobes("ldo_exec", 16'h0004, 0, 0, 1, 1, 0);
    tick(1); checkStrobes("pause_entry", 16'h0000, 0, 0, 0, 0, 0);
             checkOutput("pause_retired", retired, 8'd5);
    tick(3); checkStrobes("pause_rest", 16'h0000, 0, 0, 0, 0, 0);

    // Single step with the button held for 10 cycles
    applyStimulus(1, 1, 1, 4'h2, 0);
    tick(1); checkStrobes("step_fetch", 16'h0000, 0, 0, 0, 1, 1);
    tick(9); checkStrobes("step_held_pause", 16'h0000, 0, 0, 0, 0, 0);
             checkOutput("step_held_retired", retired, 8'd6);
    applyStimulus(1, 1, 0, 4'h2, 0);
    tick(2); checkOutput("step_release_retired", retired, 8'd6);
    applyStimulus(1, 1, 1, 4'h2, 0);
    tick(4); checkOutput("step_again_retired", retired, 8'd7);
    tick(3); checkStrobes("step_again_pause", 16'h0000, 0, 0, 0, 0, 0);

    // run dropped during EXEC of SUB
    applyStimulus(1, 0, 0, 4'hB, 0);
    tick(1);
    applyStimulus(1, 0, 1, 4'hB, 0);
    tick(1); checkStrobes("sub_fetch", 16'h0000, 0, 0, 0, 1, 1);
    tick(2); checkStrobes("sub_exec", 16'h0800, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 1, 4'hB, 0);
    tick(1); checkStrobes("sub_wb_after_stop", 16'h0800, 0, 1, 1, 1, 0);
    tick(1); checkStrobes("stop_idle", 16'h0000, 0, 0, 0, 0, 0);
             checkOutput("stop_retired", retired, 8'd8);
    tick(4); checkStrobes("stop_no_fetch", 16'h0000, 0, 0, 0, 0, 0);

    // 256 CLR instructions wrap the counter
    reset = 1'b0;
    #2 checkOutput("reset2_retired", retired, 8'd0);
    reset = 1'b1;
    applyStimulus(1, 0, 0, 4'h7, 0);
    tick(3);   checkStrobes("clr_exec_first", 16'h0080, 0, 1, 1, 1, 0);
    tick(765); checkStrobes("clr_exec_last", 16'h0080, 0, 1, 1, 1, 0);
               checkOutput("clr_last_retired", retired, 8'd255);
    applyStimulus(1, 0, 0, 4'hE, 0);
    tick(1); checkOutput("retired_wrap", retired, 8'd0);
    tick(2); checkStrobes("xor_exec", 16'h4000, 0, 0, 0, 1, 0);
    tick(1); checkStrobes("xor_wb", 16'h4000, 0, 1, 1, 1, 0);

    // Reset in WB aborts immediately
    reset = 1'b0;
    #1 checkStrobes("abort_strobes", 16'h0000, 0, 0, 0, 0, 0);
    checkOutput("abort_ir", ir, 4'h0);
    applyStimulus(0, 0, 0, 4'hE, 0);
    reset = 1'b1;
    tick(2); checkStrobes("abort_idle", 16'h0000, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 4'hE, 0);
    tick(1); checkStrobes("idle_to_fetch", 16'h0000, 0, 0, 0, 1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
